// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the load/store unit.
// Access sizes, FSM states and request legality.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RD   = 2'b01,
    S_WR   = 2'b10,
    S_RESP = 2'b11
  } state_e;

  // Size/alignment part of the legality check
  function automatic logic bad_align(
    input logic [1:0] sz,
    input logic [1:0] lo
  );
    logic r;
    r = 1'b0;
    unique case (1'b1)
      (sz == SZ_X): r = 1'b1;
      (sz == SZ_H): r = lo[0];
      (sz == SZ_W): r = (lo != 2'b00);
      default:      r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_merge.sv
// Byte-lane store merge and load extract/extend.
// Purely combinational; lanes are little-endian.
module lane_merge
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_lo,
  input  logic        i_sext,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_merged,
  output logic [31:0] o_ext
);

  logic [31:0] w_sh;

  // Insert store data into the old word; pull the addressed lane out for loads
  always_comb begin
    o_merged = i_word;
    o_ext    = i_word;
    w_sh     = i_word >> {i_lo, 3'b000};
    unique case (1'b1)
      (i_size == SZ_B): begin
        o_merged[{i_lo, 3'b000} +: 8] = i_wdata[7:0];
        o_ext = {{24{i_sext & w_sh[7]}}, w_sh[7:0]};
      end
      (i_size == SZ_H): begin
        o_merged[{i_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
        o_ext = {{16{i_sext & w_sh[15]}}, w_sh[15:0]};
      end
      default: begin
        o_merged = i_wdata;
        o_ext    = i_word;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// CPU load/store initiator for a word-addressed storage port.
// Sub-word stores run as read-modify-write.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] m_address,
  output logic [31:0]       m_datain,
  output logic              m_str,
  output logic              m_ld,
  input  logic [31:0]       m_dataout
);

  state_e      r_state;
  state_e      w_next;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_sext;
  logic [1:0]  r_lo;
  logic [31:0] r_wdata;
  logic        r_err;
  logic [31:0] r_rdata;
  logic        r_str;
  logic        r_ld;
  logic        w_bad;
  logic [31:0] w_merged;
  logic [31:0] w_ext;

  assign w_bad = bad_align(size, addr[1:0])
               | ((addr >> (ADDR_W + 2)) != 32'd0);

  lane_merge u_lane (
    .i_size   (r_size),
    .i_lo     (r_lo),
    .i_sext   (r_sext),
    .i_word   (m_dataout),
    .i_wdata  (r_wdata),
    .o_merged (w_merged),
    .o_ext    (w_ext)
  );

  // State register
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state: reject, read first, or write straight away
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (req) begin
          if (w_bad)                  w_next = S_RESP;
          else if (we && size == SZ_W) w_next = S_WR;
          else                        w_next = S_RD;
        end
      end
      S_RD:    w_next = r_we ? S_WR : S_RESP;
      S_WR:    w_next = S_RESP;
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch, storage strobes, write data and load result
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_we      <= 1'b0;
      r_size    <= 2'b00;
      r_sext    <= 1'b0;
      r_lo      <= 2'b00;
      r_wdata   <= '0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
      r_str     <= 1'b0;
      r_ld      <= 1'b0;
      m_address <= '0;
      m_datain  <= '0;
    end else begin
      r_str <= (w_next == S_WR);
      r_ld  <= (w_next == S_RD);
      unique case (r_state)
        S_IDLE: begin
          if (req) begin
            r_we      <= we;
            r_size    <= size;
            r_sext    <= sign_ext;
            r_lo      <= addr[1:0];
            r_wdata   <= wdata;
            r_err     <= w_bad;
            m_address <= addr[ADDR_W+1:2];
            if (!w_bad && we && size == SZ_W)
              m_datain <= wdata;
          end
        end
        S_RD: begin
          if (r_we) m_datain <= w_merged;
          else      r_rdata  <= w_ext;
        end
        default: ;
      endcase
    end
  end

  assign busy  = (r_state != S_IDLE);
  assign done  = (r_state == S_RESP);
  assign err   = done & r_err;
  assign rdata = r_rdata;
  assign m_str = r_str;
  assign m_ld  = r_ld;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit.
// Reference model works on a plain word array.
module tb_mem_access_unit;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          clr_n = 1'b0;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [1:0]    size = 2'b00;
  logic          sign_ext = 1'b0;
  logic [31:0]   addr = '0;
  logic [31:0]   wdata = '0;
  logic          busy, done, err;
  logic [31:0]   rdata;
  logic [AW-1:0] m_address;
  logic [31:0]   m_datain;
  logic          m_str, m_ld;
  logic [31:0]   m_dataout;

  logic [31:0] mem     [4096];
  logic [31:0] ref_mem [4096];
  logic [31:0] ref_rdata;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          acc;
    int          nstr;
    int          nld;
  } exp_t;

  exp_t sb[$];

  int cyc = 0;
  int n_tot = 0;
  int n_pass = 0;
  int mon_str = 0;
  int mon_ld = 0;

  mem_access_unit #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .req       (req),
    .we        (we),
    .size      (size),
    .sign_ext  (sign_ext),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .m_address (m_address),
    .m_datain  (m_datain),
    .m_str     (m_str),
    .m_ld      (m_ld),
    .m_dataout (m_dataout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign m_dataout = mem[m_address];
  always @(negedge clk) if (m_str) mem[m_address] <= m_datain;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference: apply the request to ref_mem and build the expected response
  function automatic exp_t model(input bit w, input logic [1:0] sz,
                                 input bit sx, input logic [31:0] a,
                                 input logic [31:0] wd, input int acc);
    exp_t e;
    int idx, sh;
    logic [31:0] word, v, mask;
    bit bad;
    bad = (sz == 3) || (sz == 1 && a[0]) || (sz == 2 && a % 4 != 0)
       || (a >= 32'h4000);
    idx = int'(a / 4) % 4096;
    sh = int'(a % 4) * 8;
    e.acc = acc;
    e.err = bad;
    e.nstr = (!bad && w) ? 1 : 0;
    e.nld = (!bad && !(w && sz == 2)) ? 1 : 0;
    e.lat = bad ? 1 : (w && sz != 2) ? 3 : 2;
    if (!bad) begin
      word = ref_mem[idx];
      mask = (sz == 0) ? 32'hFF : (sz == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
      if (w) begin
        ref_mem[idx] = (word & ~(mask << sh)) | ((wd & mask) << sh);
      end else begin
        v = (word >> sh) & mask;
        if (sx && sz == 0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
        if (sx && sz == 1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
        ref_rdata = v;
      end
    end
    e.rdata = ref_rdata;
    return e;
  endfunction

  task automatic drive(input bit w, input logic [1:0] sz, input bit sx,
                       input logic [31:0] a, input logic [31:0] wd);
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic issue(input bit w, input logic [1:0] sz, input bit sx,
                       input logic [31:0] a, input logic [31:0] wd);
    wait_idle();
    drive(w, sz, sx, a, wd);
    sb.push_back(model(w, sz, sx, a, wd, cyc + 1));
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || busy) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain_empty", sb.size(), 32'd0);
  endtask

  // Monitor: count strobes per transaction and check each done against the queue
  always @(negedge clk) begin
    exp_t e;
    if (!clr_n) begin
      mon_str = 0;
      mon_ld = 0;
    end else begin
      if (m_str) mon_str++;
      if (m_ld) mon_ld++;
      if (m_str && m_ld) chk("str_ld_overlap", 32'd1, 32'd0);
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("err", 32'(err), 32'(e.err));
          chk("rdata", rdata, e.rdata);
          chk("latency", cyc - e.acc + 1, e.lat);
          chk("str_cycles", mon_str, e.nstr);
          chk("ld_cycles", mon_ld, e.nld);
        end
        mon_str = 0;
        mon_ld = 0;
      end
    end
  end

  initial begin
    int mism;
    for (int i = 0; i < 4096; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    ref_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_str", 32'(m_str), 32'd0);
    chk("rst_ld", 32'(m_ld), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_addr", 32'(m_address), 32'd0);
    chk("rst_datain", m_datain, 32'd0);
    clr_n = 1'b1;

    issue(1, 2, 0, 32'h10, 32'hDEADBEEF);
    issue(0, 2, 0, 32'h10, 32'h0);
    drain();
    chk("t1_word4", mem[4], 32'hDEADBEEF);

    issue(1, 2, 0, 32'h10, 32'h11223344);
    issue(1, 0, 0, 32'h13, 32'h0000005A);
    drain();
    chk("t2_word4", mem[4], 32'h5A223344);

    issue(1, 2, 0, 32'h0, 32'h8081F0F0);
    issue(0, 0, 1, 32'h1, 32'h0);
    issue(0, 1, 0, 32'h2, 32'h0);
    drain();

    issue(1, 1, 0, 32'h3, 32'hFFFF);
    issue(0, 2, 0, 32'h6, 32'h0);
    issue(1, 3, 0, 32'h8, 32'h1234);
    issue(1, 2, 0, 32'h4000, 32'hCAFE);
    drain();
    chk("t4_word0", mem[0], 32'h8081F0F0);
    chk("t4_word1", mem[1], 32'h0);

    // Reset during the write cycle of a word store to word 7
    wait_idle();
    drive(1, 2, 0, 32'h1C, 32'hA5A5A5A5);
    @(posedge clk);
    #1;
    req = 1'b0;
    chk("t5_in_wr", 32'(m_str), 32'd1);
    clr_n = 1'b0;
    #1;
    chk("t5_str_drop", 32'(m_str), 32'd0);
    @(negedge clk);
    @(negedge clk);
    clr_n = 1'b1;
    ref_rdata = '0;
    @(negedge clk);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_word7", mem[7], 32'h0);

    // req held high across two loads; second accepted after first RESP
    issue(1, 2, 0, 32'h20, 32'h00C3_7E81);
    wait_idle();
    drive(0, 0, 1, 32'h20, 32'h0);
    sb.push_back(model(0, 0, 1, 32'h20, 32'h0, cyc + 1));
    @(posedge clk);
    #1;
    drive(0, 1, 1, 32'h22, 32'h0);
    wait_idle();
    sb.push_back(model(0, 1, 1, 32'h22, 32'h0, cyc + 1));
    @(negedge clk);
    req = 1'b0;
    drain();

    // req pulsed while busy must be ignored
    issue(1, 0, 0, 32'h21, 32'h77);
    drive(0, 2, 0, 32'h20, 32'h0);
    @(negedge clk);
    req = 1'b0;
    drain();

    for (int k = 0; k < 200; k++) begin
      logic [31:0] a;
      a = $urandom_range(0, 63);
      if ($urandom_range(0, 15) == 0) a = a | 32'h0001_0000;
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), a, $urandom);
    end
    drain();

    mism = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) mism++;
    chk("final_mem", mism, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
